uart_tx_fifo: RTL and testbench

- Byte buffer and issue sequencer placed directly upstream of uart_tx.
- Accepts bytes from a valid/ready producer (CPU bridge, echo path) and stores them in a circular FIFO.
- Drains the FIFO into uart_tx one byte at a time, pulsing tx_enable and honouring tx_busy, so the producer never has to track UART timing.

---
 rtl/uart_tx_fifo.sv | 106 ++++++++++
 tb/tb_uart_tx_fifo.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Byte FIFO plus issue sequencer feeding uart_tx: buffers producer bytes and
// hands them to the transmitter one at a time, pacing on tx_busy.
module uart_tx_fifo #(
  parameter int unsigned Depth = 16,
  localparam int unsigned AddrWidth = $clog2(Depth)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_wr_valid,
  input  logic [7:0]         i_wr_data,
  output logic               o_wr_ready,
  output logic               o_full,
  output logic               o_empty,
  output logic [AddrWidth:0] o_level,
  output logic               o_drop,
  output logic               o_tx_enable,
  output logic [7:0]         o_tx_data,
  input  logic               i_tx_busy
);

  localparam logic [AddrWidth:0] LevelFull = Depth[AddrWidth:0];

  typedef enum logic [1:0] {StIdle, StIssue, StGuard, StWait} state_e;

  state_e               state_q, state_d;
  logic [7:0]           mem_q [Depth];
  logic [AddrWidth-1:0] wr_ptr_q, rd_ptr_q;
  logic [AddrWidth:0]   level_q, level_d;
  logic [7:0]           tx_data_q;
  logic                 drop_q;
  logic                 full, empty, push, pop;

  // Acceptance depends only on the registered level, so a same-cycle pop
  // never frees a slot for a write.
  assign full  = (level_q == LevelFull);
  assign empty = (level_q == '0);
  assign push  = i_wr_valid && !full;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (!empty && !i_tx_busy) state_d = StIssue;
      StIssue: state_d = StGuard;
      // uart_tx may not have raised busy yet, so it is not sampled here.
      StGuard: state_d = StWait;
      StWait:  if (!i_tx_busy) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    pop         = (state_q == StIdle) && !empty && !i_tx_busy;
    o_tx_enable = (state_q == StIssue);
  end

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      tx_data_q <= 8'h00;
      drop_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q  <= rd_ptr_q + 1'b1;
        tx_data_q <= mem_q[rd_ptr_q];
      end
      level_q <= level_d;
      drop_q  <= i_wr_valid && full;
    end
  end

  // Storage needs no reset; pointers and level define what is valid.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= i_wr_data;
  end

  assign o_wr_ready = !full;
  assign o_full     = full;
  assign o_empty    = empty;
  assign o_level    = level_q;
  assign o_drop     = drop_q;
  assign o_tx_data  = tx_data_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a per-cycle vector table plus sequences for
// latency, full/drop, pointer wrap and reset while a byte is in flight.
module tb_uart_tx_fifo;

  localparam int BusyLen = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready, full, empty, drop, tx_enable, tx_busy;
  logic [4:0] level;
  logic [7:0] tx_data;

  logic model_on = 1'b0;
  logic busy_man = 1'b0;
  logic en_d1    = 1'b0;
  int   busy_cnt = 0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];

  uart_tx_fifo #(.Depth(16)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_wr_valid (wr_valid),
    .i_wr_data  (wr_data),
    .o_wr_ready (wr_ready),
    .o_full     (full),
    .o_empty    (empty),
    .o_level    (level),
    .o_drop     (drop),
    .o_tx_enable(tx_enable),
    .o_tx_data  (tx_data),
    .i_tx_busy  (tx_busy)
  );

  always #5 clk = ~clk;

  // Transmitter stand-in: busy rises two cycles after the enable pulse.
  always @(posedge clk) begin
    en_d1 <= tx_enable;
    if (en_d1) busy_cnt <= BusyLen;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end

  assign tx_busy = model_on ? (busy_cnt != 0) : busy_man;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (tx_enable) begin
      rx_q.push_back(tx_data);
      chk("no_enable_while_busy", {31'd0, tx_busy}, 32'd0);
    end
    chk("level_bound", {31'd0, level <= 5'd16}, 32'd1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    wr_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    wr_valid = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic wait_drain(input int n, input int budget, input string name);
    int cyc = 0;
    while ((rx_q.size() < n || !empty) && cyc < budget) begin
      @(posedge clk);
      cyc++;
    end
    idle(25);
    chk({name, "_count"}, rx_q.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < rx_q.size() && i < exp_q.size()) chk({name, "_byte"}, rx_q[i], exp_q[i]);
    end
  endtask

  typedef struct {
    logic       wv;
    logic [7:0] d;
    logic       busy;
    logic [4:0] lvl;
    logic       emp;
    logic       ful;
    logic       en;
    logic       drp;
    logic [7:0] data;
  } vec_t;

  vec_t vecs[14];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // wv  d       busy  lvl   emp   ful   en    drp   data
    vecs[0]  = '{1'b1, 8'h11, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[1]  = '{1'b1, 8'h22, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[2]  = '{1'b0, 8'h00, 1'b0, 5'd1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h11};
    vecs[3]  = '{1'b1, 8'h33, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11};
    vecs[4]  = '{1'b0, 8'h00, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11};
    vecs[5]  = '{1'b0, 8'h00, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11};
    vecs[6]  = '{1'b0, 8'h00, 1'b0, 5'd1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h22};
    vecs[7]  = '{1'b0, 8'h00, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h22};
    vecs[8]  = '{1'b0, 8'h00, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h22};
    vecs[9]  = '{1'b0, 8'h00, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h22};
    vecs[10] = '{1'b0, 8'h00, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h22};
    vecs[11] = '{1'b0, 8'h00, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h22};
    vecs[12] = '{1'b1, 8'h44, 1'b0, 5'd1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h33};
    vecs[13] = '{1'b1, 8'h55, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h33};

    rst      = 1'b0;
    wr_valid = 1'b0;
    wr_data  = 8'h00;
    step();

    // Reset state and first-byte latency
    do_reset();
    chk("rst_level", level, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_drop", drop, 0);
    chk("rst_enable", tx_enable, 0);
    chk("rst_data", tx_data, 8'h00);
    wr_valid = 1'b1;
    wr_data  = 8'hA5;
    step();
    wr_valid = 1'b0;
    chk("lat_n_enable", tx_enable, 0);
    chk("lat_n_level", level, 1);
    step();
    chk("lat_n1_enable", tx_enable, 1);
    chk("lat_n1_data", tx_data, 8'hA5);
    chk("lat_n1_level", level, 0);
    step();
    chk("lat_n2_enable", tx_enable, 0);
    chk("lat_n2_data", tx_data, 8'hA5);
    idle(5);

    // Cycle-by-cycle vector table
    do_reset();
    for (int i = 0; i < 14; i++) begin
      wr_valid = vecs[i].wv;
      wr_data  = vecs[i].d;
      busy_man = vecs[i].busy;
      step();
      chk($sformatf("vec%0d_level", i), level, vecs[i].lvl);
      chk($sformatf("vec%0d_empty", i), empty, vecs[i].emp);
      chk($sformatf("vec%0d_full", i), full, vecs[i].ful);
      chk($sformatf("vec%0d_enable", i), tx_enable, vecs[i].en);
      chk($sformatf("vec%0d_drop", i), drop, vecs[i].drp);
      chk($sformatf("vec%0d_data", i), tx_data, vecs[i].data);
    end
    wr_valid = 1'b0;
    busy_man = 1'b0;

    // Fill to full, rejected writes, then in-order drain
    do_reset();
    idle(25);
    busy_man = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'(i);
      step();
    end
    chk("full_flag", full, 1);
    chk("full_wr_ready", wr_ready, 0);
    chk("full_level", level, 16);
    chk("full_drop_idle", drop, 0);
    wr_data = 8'hFF;
    step();
    chk("drop_pulse", drop, 1);
    chk("drop_level", level, 16);
    rx_q.delete();
    busy_man = 1'b0;
    step();
    chk("drop_with_pop", drop, 1);
    chk("drop_with_pop_level", level, 15);
    chk("drop_with_pop_enable", tx_enable, 1);
    wr_valid = 1'b0;
    model_on = 1'b1;
    step();
    chk("drop_clears", drop, 0);
    chk("drop_clears_level", level, 15);
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(i));
    wait_drain(16, 1500, "burst");

    // Pointer wrap with the busy model in the loop
    do_reset();
    rx_q.delete();
    exp_q.delete();
    for (int i = 0; i < 10; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'h20 + 8'(i);
      exp_q.push_back(wr_data);
      step();
    end
    wr_valid = 1'b0;
    wait_drain(10, 1000, "wrap_a");
    for (int i = 0; i < 12; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'h40 + 8'(i);
      exp_q.push_back(wr_data);
      step();
    end
    wr_valid = 1'b0;
    wait_drain(22, 1200, "wrap_b");

    // Reset during WAIT with bytes queued and a byte still in flight
    model_on = 1'b0;
    busy_man = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'h60 + 8'(i);
      step();
    end
    wr_valid = 1'b0;
    busy_man = 1'b0;
    step();
    chk("rw_pop_enable", tx_enable, 1);
    step();
    busy_man = 1'b1;
    step();
    step();
    chk("rw_level_before", level, 4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rw_level", level, 0);
    chk("rw_empty", empty, 1);
    chk("rw_enable", tx_enable, 0);
    chk("rw_data", tx_data, 8'h00);
    rx_q.delete();
    idle(10);
    busy_man = 1'b0;
    idle(5);
    chk("rw_no_enable_empty", rx_q.size(), 0);
    busy_man = 1'b1;
    wr_valid = 1'b1;
    wr_data  = 8'h77;
    step();
    wr_valid = 1'b0;
    idle(5);
    chk("rw_held_by_busy", rx_q.size(), 0);
    chk("rw_held_level", level, 1);
    busy_man = 1'b0;
    repeat (4) step();
    chk("rw_issue_count", rx_q.size(), 1);
    if (rx_q.size() > 0) chk("rw_issue_byte", rx_q[0], 8'h77);
    chk("rw_final_level", level, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
